requant_relu_q: RTL
===================

Name: requant_relu_q

Overview:
- Requantization stage placed directly downstream of the INT8 linear layer.
- Snapshots the layer's DIM-wide signed ACC-width output vector and rescales each element by a fixed-point multiplier and rounding right-shift.
- Applies optional ReLU and saturates to signed OUT_W; the result vector feeds the next layer's x_in.
- Handshake mirrors the layer's: level start in, sticky done out.

Parameters:
- DIM, 8, vector length; equals the upstream OUT_DIM.
- IN_W, 32, input element width (signed); equals the upstream OUT_DATA_W.
- OUT_W, 8, output element width (signed); equals the next layer's IN_DATA_W.
- MULT_W, 16, width of the signed scale multiplier.
- M_SCALE, 16384, signed multiplier value; effective scale is M_SCALE / 2^SHIFT.
- SHIFT, 16, arithmetic right-shift amount, range 0..IN_W+MULT_W-1.
- RELU_EN, 1, when 1 the lower clamp is 0; when 0 it is -2^(OUT_W-1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  level request; sampled in IDLE; must drop before a new run.
- x_in  in  signed [IN_W-1:0] x DIM  unpacked input vector; tie to the upstream y_out.
- y_out  out  signed [OUT_W-1:0] x DIM  unpacked registered result vector.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  high in DONE.

Behaviour:
Reset:
- rst is asynchronous, active-high; clk is the clock.
- On reset: state=IDLE, all y_out=0, done=0, busy=0, pipeline valids=0, index=0.
- Reset asserted mid-run aborts immediately; no partial-run data survives.

States:
- IDLE:
  - done=0.
  - On start=1 at an edge: copy all x_in into an internal buffer xb, idx<=0, go to RUN.
  - x_in is don't-care after this capture edge.
- RUN:
  - Each edge: stage-1 register p<=xb[idx]*M_SCALE (full width P_W=IN_W+MULT_W, signed), v1<=1, tag1<=idx, idx++.
  - On the edge issuing idx=DIM-1, go to DRAIN.
- DRAIN:
  - v1<=0.
  - Stage 2 retires the last element this edge, then go to DONE.
- DONE:
  - done<=1.
  - If start=0, go to IDLE (done<=0 on that edge).
  - While start stays high, remain in DONE; no retrigger.
- Stage 2 runs every edge with v1=1: y_out[tag1]<=sat(relu(round(p))).
- Start is ignored outside IDLE.

Arithmetic:
- round(p) = (p + 2^(SHIFT-1)) >>> SHIFT, computed in P_W+1 bits so the add cannot overflow. This is round-half-toward-+inf.
- SHIFT=0: no rounding term, round(p)=p.
- Clamp upper bound is 2^(OUT_W-1)-1.
- Clamp lower bound is 0 if RELU_EN=1, else -2^(OUT_W-1).
- Comparisons are done at full width before truncation to OUT_W.

Latency and output timing:
- The start-sampling edge is edge 0.
- y_out[k] is written on edge k+2.
- The last write is on edge DIM+1.
- done rises after edge DIM+2, i.e. 10 edges for DIM=8.
- Elements not yet rewritten keep their previous-run values; consumers must use y_out only while done=1.
- y_out is held stable from done=1 until the next run's edge 2.

Test Plan:
- Defaults (M_SCALE=16384, SHIFT=16, RELU_EN=1), x_in={100,102,-100,1000,0,3,2,-1} -> y_out={25,26,0,127,0,1,1,0}; done rises exactly 10 edges after the start-sampling edge; busy high for edges 1..DIM+1.
- RELU_EN=0, x_in={-1000,-6,-5,-2,1000,4,-4,0} -> y_out={-128,-1,-1,0,127,1,-1,0}; checks negative rounding and both saturation rails.
- Change x_in to all 0x7FFFFFFF on the edge after start is sampled -> results still match the captured vector; start held high 20 extra cycles -> done stays 1, no second run; drop start -> done=0 the next edge; reassert start -> a new run completes.
- Assert rst at edge 5 of a run -> y_out all 0, done=0, busy=0 immediately (asynchronous); next start gives a correct full result.
- Chain behind the linear layer (upstream done drives this block's start) with random INT8 vectors -> y_out matches the golden model requant(sat32(Wx+b)) for 200 vectors.

Source files
------------

// File: rtl/requant_relu_q.sv
// Requantization stage behind the INT8 linear layer.
// Captures the layer's DIM-wide accumulator vector, then streams each element
// through a two-stage pipeline: multiply by M_SCALE, then round-shift, optional
// ReLU and saturation to signed OUT_W. Level start in, sticky done out.
module requant_relu_q #(
    parameter int DIM     = 8,
    parameter int IN_W    = 32,
    parameter int OUT_W   = 8,
    parameter int MULT_W  = 16,
    parameter int M_SCALE = 16384,
    parameter int SHIFT   = 16,
    parameter int RELU_EN = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic signed [IN_W-1:0]  x_in  [DIM],
    output logic signed [OUT_W-1:0] y_out [DIM],
    output logic                    busy,
    output logic                    done
);

    localparam int P_W   = IN_W + MULT_W;
    localparam int IDX_W = (DIM > 1) ? $clog2(DIM) : 1;

    localparam logic signed [MULT_W-1:0] M_S = MULT_W'(M_SCALE);
    // Rounding constant 2^(SHIFT-1); zero when there is no shift at all.
    localparam logic signed [P_W:0] HALF =
        (SHIFT > 0) ? ((P_W+1)'(1) <<< ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
    localparam logic signed [P_W:0] CLAMP_HI  = (P_W+1)'(2**(OUT_W-1) - 1);
    localparam logic signed [P_W:0] CLAMP_NEG = -((P_W+1)'(2**(OUT_W-1)));
    localparam logic signed [P_W:0] CLAMP_LO  = (RELU_EN != 0) ? '0 : CLAMP_NEG;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   idx_reg, idx_next;
    logic               done_reg, done_next;
    logic               capture;
    logic               issue;

    logic signed [IN_W-1:0]  xb_reg [DIM];
    logic signed [P_W-1:0]   p_reg;
    logic                    v1_reg;
    logic [IDX_W-1:0]        tag1_reg;

    logic signed [IN_W-1:0]  x_sel;
    logic signed [P_W-1:0]   prod;
    logic signed [P_W:0]     p_ext;
    logic signed [P_W:0]     rnd;
    logic signed [OUT_W-1:0] sat_val;

    // Control state, element index and sticky done flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
            idx_reg   <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            done_reg  <= done_next;
        end
    end

    // Next-state logic: capture in IDLE, issue one element per cycle in RUN,
    // one drain cycle for the last element, then hold done until start drops.
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        done_next  = done_reg;
        capture    = 1'b0;
        issue      = 1'b0;
        case (state_reg)
            S_IDLE: begin
                done_next = 1'b0;
                if (start) begin
                    capture    = 1'b1;
                    idx_next   = '0;
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                issue    = 1'b1;
                idx_next = idx_reg + IDX_W'(1);
                if (idx_reg == IDX_W'(DIM - 1)) begin
                    idx_next   = '0;
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                state_next = S_DONE;
            end
            S_DONE: begin
                // done is raised on the first DONE edge; only a low start
                // seen while done is already up returns to IDLE.
                if (!done_reg) begin
                    done_next = 1'b1;
                end else if (!start) begin
                    done_next  = 1'b0;
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Snapshot of the upstream vector; x_in is ignored after the capture edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DIM; i++) xb_reg[i] <= '0;
        end else if (capture) begin
            for (int i = 0; i < DIM; i++) xb_reg[i] <= x_in[i];
        end
    end

    assign x_sel = xb_reg[idx_reg];
    assign prod  = P_W'(x_sel) * P_W'(M_S);

    // Stage 1: full-width product of the issued element, tagged with its index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_reg    <= '0;
            v1_reg   <= 1'b0;
            tag1_reg <= '0;
        end else begin
            v1_reg <= issue;
            if (issue) begin
                p_reg    <= prod;
                tag1_reg <= idx_reg;
            end
        end
    end

    // Round half toward +inf in one extra bit, then clamp at full width.
    assign p_ext = {p_reg[P_W-1], p_reg};
    assign rnd   = (p_ext + HALF) >>> SHIFT;

    always_comb begin
        sat_val = rnd[OUT_W-1:0];
        if (rnd > CLAMP_HI) begin
            sat_val = CLAMP_HI[OUT_W-1:0];
        end else if (rnd < CLAMP_LO) begin
            sat_val = CLAMP_LO[OUT_W-1:0];
        end
    end

    // Stage 2: write the requantized element back to its slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DIM; i++) y_out[i] <= '0;
        end else if (v1_reg) begin
            y_out[tag1_reg] <= sat_val;
        end
    end

    assign busy = (state_reg == S_RUN) || (state_reg == S_DRAIN);
    assign done = done_reg;

endmodule
